// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shifts (1 bit/cycle) and shift-add multiply.
// Latency 0 / k / TAM edges after start into DONE; start is ignored while busy (no queuing).
module ula_seq #(
   parameter int TAM = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [3:0]     op,
   input  logic [TAM-1:0] opA,
   input  logic [TAM-1:0] opB,
   input  logic [3:0]     dest_in,
   output logic [TAM-1:0] result,
   output logic [3:0]     dest_out,
   output logic           wr_en,
   output logic           busy,
   output logic           zero,
   output logic           carry
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_MUL   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam int CW = ($clog2(TAM + 1) > 4) ? $clog2(TAM + 1) : 4;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [TAM-1:0]   a_r;
   logic [TAM-1:0]   sh_r;
   logic             shr_r;
   logic [3:0]       dest_r;
   logic [2*TAM-1:0] prod;

   logic [TAM-1:0]   alu_res;
   logic             alu_c;
   logic             legal;
   logic [TAM-1:0]   sh_next;
   logic             sh_out;
   logic [TAM:0]     msum;
   logic [2*TAM-1:0] prod_next;

   assign busy  = (state != S_IDLE);
   assign legal = (op <= 4'd9);

   // Single-cycle results; shifts reach here only with a zero shift count
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         4'd0:    {alu_c, alu_res} = {1'b0, opA} + {1'b0, opB};
         4'd1:    {alu_c, alu_res} = {1'b0, opA} - {1'b0, opB};
         4'd2:    alu_res = opA & opB;
         4'd3:    alu_res = opA | opB;
         4'd4:    alu_res = opA ^ opB;
         4'd5:    alu_res = ~opA;
         4'd6,
         4'd7:    alu_res = opA;
         4'd9:    alu_res = opB;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      sh_next = shr_r ? (sh_r >> 1) : (sh_r << 1);
      sh_out  = shr_r ? sh_r[0] : sh_r[TAM-1];
      msum      = {1'b0, prod[2*TAM-1:TAM]} + (prod[0] ? {1'b0, a_r} : '0);
      prod_next = {msum, prod[TAM-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         a_r      <= '0;
         sh_r     <= '0;
         shr_r    <= 1'b0;
         dest_r   <= '0;
         prod     <= '0;
         result   <= '0;
         dest_out <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         wr_en    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               dest_r <= dest_in;
               a_r    <= opA;
               shr_r  <= (op == OP_SHR);
               if ((op == OP_SHL || op == OP_SHR) && opB[3:0] != 4'd0) begin
                  sh_r  <= opA;
                  cnt   <= CW'(opB[3:0]);
                  state <= S_SHIFT;
               end else if (op == OP_MUL) begin
                  prod  <= {{TAM{1'b0}}, opB};
                  cnt   <= CW'(TAM);
                  state <= S_MUL;
               end else begin
                  state <= S_DONE;
                  if (legal) begin
                     result   <= alu_res;
                     zero     <= (alu_res == '0);
                     carry    <= alu_c;
                     dest_out <= dest_in;
                     wr_en    <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               sh_r <= sh_next;
               cnt  <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state    <= S_DONE;
                  result   <= sh_next;
                  zero     <= (sh_next == '0);
                  carry    <= sh_out;
                  dest_out <= dest_r;
                  wr_en    <= 1'b1;
               end
            end
            S_MUL: begin
               prod <= prod_next;
               cnt  <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state    <= S_DONE;
                  result   <= prod_next[TAM-1:0];
                  zero     <= (prod_next[TAM-1:0] == '0);
                  carry    <= |prod_next[2*TAM-1:TAM];
                  dest_out <= dest_r;
                  wr_en    <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_ula_seq;
   localparam int TAM = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [3:0]     op;
   logic [TAM-1:0] opA;
   logic [TAM-1:0] opB;
   logic [3:0]     dest_in;
   logic [TAM-1:0] result;
   logic [3:0]     dest_out;
   logic           wr_en;
   logic           busy;
   logic           zero;
   logic           carry;

   int checks = 0;
   int errors = 0;

   ula_seq #(.TAM(TAM)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
      .dest_in(dest_in), .result(result), .dest_out(dest_out), .wr_en(wr_en),
      .busy(busy), .zero(zero), .carry(carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what an op must produce and how many edges after acceptance it finishes
   function automatic void ref_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic lg,
                                  output int l);
      logic [16:0] s;
      logic [31:0] p;
      int k;
      r = 16'h0; c = 1'b0; lg = 1'b1; l = 0;
      k = int'(b[3:0]);
      case (o)
         4'd0: begin s = 17'(a) + 17'(b); r = s[15:0]; c = s[16]; end
         4'd1: begin r = a - b; c = (a < b); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: begin r = a << k; c = (k > 0) ? a[16-k] : 1'b0; l = k; end
         4'd7: begin r = a >> k; c = (k > 0) ? a[k-1] : 1'b0; l = k; end
         4'd8: begin p = 32'(a) * 32'(b); r = p[15:0]; c = (p[31:16] != 16'h0); l = 16; end
         4'd9: r = b;
         default: lg = 1'b0;
      endcase
   endfunction

   int          m_phase;   // 0 idle, 1 working, 2 done
   int          m_left;
   logic [15:0] m_res, p_res;
   logic [3:0]  m_dest, p_dest;
   logic        m_zero, m_carry, m_wr, p_carry, p_legal;

   task automatic m_finish();
      m_phase = 2;
      if (p_legal) begin
         m_res = p_res; m_dest = p_dest; m_zero = (p_res == 16'h0); m_carry = p_carry; m_wr = 1'b1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_left = 0; m_res = '0; m_dest = '0; m_zero = 0; m_carry = 0; m_wr = 0;
      end else begin
         m_wr = 1'b0;
         if (m_phase == 2) m_phase = 0;
         else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_finish();
         end else if (start) begin
            ref_op(op, opA, opB, p_res, p_carry, p_legal, m_left);
            p_dest = dest_in;
            if (m_left == 0) m_finish();
            else m_phase = 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      chk("result", 32'(result), 32'(m_res));
      chk("dest_out", 32'(dest_out), 32'(m_dest));
      chk("zero", 32'(zero), 32'(m_zero));
      chk("carry", 32'(carry), 32'(m_carry));
   end

   task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input logic [15:0] er, input logic ez,
                        input logic ec, input int el);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; opA = a; opB = b; dest_in = d;
      @(negedge clk);
      start = 1'b0; op = 4'($urandom); opA = 16'($urandom); opB = 16'($urandom); dest_in = 4'($urandom);
      n = 1;
      while (!wr_en && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(el + 1));
      chk("lit_busy", 32'(busy), 32'd1);
      chk("lit_result", 32'(result), 32'(er));
      chk("lit_dest", 32'(dest_out), 32'(d));
      chk("lit_zero", 32'(zero), 32'(ez));
      chk("lit_carry", 32'(carry), 32'(ec));
      @(negedge clk);
      chk("lit_idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int wr_cnt;
      rst = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0; dest_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      do_op(4'd0, 16'h7FFF, 16'h0001, 4'd3,  16'h8000, 1'b0, 1'b0, 0);
      do_op(4'd0, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 1'b1, 0);
      do_op(4'd1, 16'h0005, 16'h0007, 4'd7,  16'hFFFE, 1'b0, 1'b1, 0);
      do_op(4'd2, 16'hF0F0, 16'h3C3C, 4'd1,  16'h3030, 1'b0, 1'b0, 0);
      do_op(4'd3, 16'hF000, 16'h000F, 4'd2,  16'hF00F, 1'b0, 1'b0, 0);
      do_op(4'd4, 16'hAAAA, 16'hFFFF, 4'd4,  16'h5555, 1'b0, 1'b0, 0);
      do_op(4'd5, 16'h00FF, 16'h1234, 4'd5,  16'hFF00, 1'b0, 1'b0, 0);
      do_op(4'd9, 16'h1111, 16'hBEEF, 4'd15, 16'hBEEF, 1'b0, 1'b0, 0);
      do_op(4'd6, 16'h8001, 16'h0004, 4'd6,  16'h0010, 1'b0, 1'b0, 4);
      do_op(4'd6, 16'h1234, 16'h0010, 4'd8,  16'h1234, 1'b0, 1'b0, 0);
      do_op(4'd6, 16'h1001, 16'h0004, 4'd8,  16'h0010, 1'b0, 1'b1, 4);
      do_op(4'd7, 16'h0001, 16'h0001, 4'd9,  16'h0000, 1'b1, 1'b1, 1);
      do_op(4'd7, 16'h8000, 16'h000F, 4'd10, 16'h0001, 1'b0, 1'b0, 15);
      do_op(4'd8, 16'h0100, 16'h0100, 4'd11, 16'h0000, 1'b1, 1'b1, 16);
      do_op(4'd8, 16'h00FF, 16'h0003, 4'd12, 16'h02FD, 1'b0, 1'b0, 16);

      // Illegal opcode: one busy cycle, no write, outputs keep 0x02FD / dest 12
      @(negedge clk);
      start = 1'b1; op = 4'hF; opA = 16'h0; opB = 16'h0; dest_in = 4'd1;
      @(negedge clk);
      start = 1'b0;
      chk("ill_busy", 32'(busy), 32'd1);
      chk("ill_wr", 32'(wr_en), 32'd0);
      chk("ill_result", 32'(result), 32'h02FD);
      chk("ill_dest", 32'(dest_out), 32'd12);
      @(negedge clk);
      chk("ill_idle", 32'(busy), 32'd0);

      // Start pulses while multiplying must not queue a second operation
      @(negedge clk);
      start = 1'b1; op = 4'd8; opA = 16'd3; opB = 16'd5; dest_in = 4'd2;
      wr_cnt = 0;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         start = (i < 12) ? (i % 2 == 0) : 1'b0;
         op = 4'd0; opA = 16'h1; opB = 16'h1;
         if (wr_en) begin
            wr_cnt++;
            chk("mul_busy_res", 32'(result), 32'd15);
         end
      end
      chk("mul_single_wr", 32'(wr_cnt), 32'd1);

      // Async reset in the middle of a multiply
      @(negedge clk);
      start = 1'b1; op = 4'd8; opA = 16'h0100; opB = 16'h0100; dest_in = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_wr", 32'(wr_en), 32'd0);
      chk("arst_dest", 32'(dest_out), 32'd0);
      chk("arst_flags", 32'({zero, carry}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_op(4'd0, 16'h0002, 16'h0002, 4'd4, 16'h0004, 1'b0, 1'b0, 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
